e_mdu: RTL and testbench

//  Multiply/divide unit of the E stage, directly upstream of the M-stage controller.

---
 rtl/md_pkg.sv | 44 ++++
 rtl/md_arith.sv | 59 +++++
 rtl/e_mdu.sv | 105 ++++++++++
 tb/tb_e_mdu.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/md_pkg.sv
// Shared md-class decode for the D/E/M controllers: op encoding, class helpers, default latencies.
// MDU_MADD_EN enables the madd/maddu/msub/msubu ops; otherwise they decode as NONE.
package md_pkg;

    typedef enum logic [3:0] {
        NONE  = 4'd0,
        MULT  = 4'd1,
        MULTU = 4'd2,
        DIV   = 4'd3,
        DIVU  = 4'd4,
        MTHI  = 4'd5,
        MTLO  = 4'd6,
        MADD  = 4'd7,
        MADDU = 4'd8,
        MSUB  = 4'd9,
        MSUBU = 4'd10
    } md_op_t;

    typedef enum logic {
        MD_IDLE = 1'b0,
        MD_BUSY = 1'b1
    } md_state_t;

    localparam int unsigned MULT_CYC_DEF = 5;
    localparam int unsigned DIV_CYC_DEF  = 10;

    function automatic logic is_mul_class(input md_op_t op);
        logic r;
        r = 1'b0;
        case (op)
            MULT, MULTU: r = 1'b1;
`ifdef MDU_MADD_EN
            MADD, MADDU, MSUB, MSUBU: r = 1'b1;
`endif
            default: r = 1'b0;
        endcase
        return r;
    endfunction

    function automatic logic is_div_class(input md_op_t op);
        return (op == DIV) || (op == DIVU);
    endfunction

endpackage

// File: rtl/md_arith.sv
// Combinational 64-bit {hi,lo} result for the md-class op issued at start.
// MDU_MADD_EN adds accumulate/subtract onto the supplied {hi,lo}.
module md_arith
    import md_pkg::*;
(
    input  md_op_t      op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [31:0] hi,
    input  logic [31:0] lo,
    output logic [31:0] res_hi,
    output logic [31:0] res_lo
);

    logic [63:0] sprod;
    logic [63:0] uprod;
    logic        sgn_div;
    logic [31:0] dvd;
    logic [31:0] dvs;
    logic [31:0] uq;
    logic [31:0] ur;
    logic [31:0] q;
    logic [31:0] r;

    // Low 64 bits of a sign-extended product equal the signed product.
    assign sprod = {{32{a[31]}}, a} * {{32{b[31]}}, b};
    assign uprod = {32'b0, a} * {32'b0, b};

    // Signed divide via magnitudes; 0x80000000/-1 falls out as 0x80000000 rem 0.
    assign sgn_div = (op == DIV);
    assign dvd     = (sgn_div && a[31]) ? (32'd0 - a) : a;
    assign dvs     = (b == '0) ? 32'd1 : ((sgn_div && b[31]) ? (32'd0 - b) : b);
    assign uq      = dvd / dvs;
    assign ur      = dvd % dvs;
    assign q       = (sgn_div && (a[31] ^ b[31])) ? (32'd0 - uq) : uq;
    assign r       = (sgn_div && a[31]) ? (32'd0 - ur) : ur;

    always_comb begin
        {res_hi, res_lo} = {hi, lo};
        case (op)
            MULT:  {res_hi, res_lo} = sprod;
            MULTU: {res_hi, res_lo} = uprod;
            DIV, DIVU: begin
                if (b != '0) begin
                    res_hi = r;
                    res_lo = q;
                end
            end
`ifdef MDU_MADD_EN
            MADD:  {res_hi, res_lo} = {hi, lo} + sprod;
            MADDU: {res_hi, res_lo} = {hi, lo} + uprod;
            MSUB:  {res_hi, res_lo} = {hi, lo} - sprod;
            MSUBU: {res_hi, res_lo} = {hi, lo} - uprod;
`endif
            default: {res_hi, res_lo} = {hi, lo};
        endcase
    end

endmodule

// File: rtl/e_mdu.sv
// E-stage multiply/divide unit: issue FSM, latency counter, pending result and HI/LO registers.
// MDU_MADD_EN enables madd/maddu/msub/msubu (multiply-class, MULT_CYC latency).
module e_mdu
    import md_pkg::*;
#(
    parameter int unsigned MULT_CYC = MULT_CYC_DEF,
    parameter int unsigned DIV_CYC  = DIV_CYC_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        md_valid,
    input  logic [3:0]  md_op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        start,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam int unsigned CYC_MAX = (MULT_CYC > DIV_CYC) ? MULT_CYC : DIV_CYC;
    localparam int unsigned CNT_W   = $clog2(CYC_MAX + 1);
    localparam logic [CNT_W-1:0] MULT_LD = CNT_W'(MULT_CYC);
    localparam logic [CNT_W-1:0] DIV_LD  = CNT_W'(DIV_CYC);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    md_state_t        state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic             busy_n;
    logic [31:0]      hi_n, lo_n;
    logic [31:0]      res_hi, res_lo, res_hi_n, res_lo_n;
    logic [31:0]      ar_hi, ar_lo;
    md_op_t           op;

    assign op = md_op_t'(md_op);

    md_arith u_arith (
        .op     (op),
        .a      (a),
        .b      (b),
        .hi     (hi),
        .lo     (lo),
        .res_hi (ar_hi),
        .res_lo (ar_lo)
    );

    always_comb begin
        state_n  = state;
        cnt_n    = cnt;
        busy_n   = busy;
        hi_n     = hi;
        lo_n     = lo;
        res_hi_n = res_hi;
        res_lo_n = res_lo;
        start    = md_valid && (state == MD_IDLE) && (is_mul_class(op) || is_div_class(op));

        case (state)
            MD_IDLE: begin
                if (start) begin
                    res_hi_n = ar_hi;
                    res_lo_n = ar_lo;
                    cnt_n    = is_div_class(op) ? DIV_LD : MULT_LD;
                    busy_n   = 1'b1;
                    state_n  = MD_BUSY;
                end else if (md_valid && (op == MTHI)) begin
                    hi_n = a;
                end else if (md_valid && (op == MTLO)) begin
                    lo_n = a;
                end
            end
            MD_BUSY: begin
                // md_valid is deliberately ignored here; the hazard unit should have stalled it.
                cnt_n = cnt - CNT_ONE;
                if (cnt == CNT_ONE) begin
                    hi_n    = res_hi;
                    lo_n    = res_lo;
                    busy_n  = 1'b0;
                    state_n = MD_IDLE;
                end
            end
            default: state_n = MD_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= MD_IDLE;
            cnt    <= '0;
            busy   <= 1'b0;
            hi     <= '0;
            lo     <= '0;
            res_hi <= '0;
            res_lo <= '0;
        end else begin
            state  <= state_n;
            cnt    <= cnt_n;
            busy   <= busy_n;
            hi     <= hi_n;
            lo     <= lo_n;
            res_hi <= res_hi_n;
            res_lo <= res_lo_n;
        end
    end

endmodule

// File: tb/tb_e_mdu.sv
// Scoreboard bench for e_mdu: expected {hi,lo} and busy length queued at issue, checked at commit.
module tb_e_mdu;
    import md_pkg::*;

    localparam int unsigned MC = 5;
    localparam int unsigned DC = 10;

    logic        clk = 1'b0;
    logic        reset;
    logic        md_valid;
    logic [3:0]  md_op;
    logic [31:0] a, b;
    logic        start, busy;
    logic [31:0] hi, lo;

    e_mdu #(.MULT_CYC(MC), .DIV_CYC(DC)) dut (
        .clk      (clk),
        .reset    (reset),
        .md_valid (md_valid),
        .md_op    (md_op),
        .a        (a),
        .b        (b),
        .start    (start),
        .busy     (busy),
        .hi       (hi),
        .lo       (lo)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] res;
        int unsigned cyc;
    } exp_t;

    exp_t        sb[$];
    int          checks = 0;
    int          errors = 0;
    logic [31:0] mhi = '0;
    logic [31:0] mlo = '0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic tb_is_mul(input logic [3:0] op);
        logic r;
        r = (op == MULT) || (op == MULTU);
`ifdef MDU_MADD_EN
        r = r || (op == MADD) || (op == MADDU) || (op == MSUB) || (op == MSUBU);
`endif
        return r;
    endfunction

    function automatic logic tb_is_div(input logic [3:0] op);
        return (op == DIV) || (op == DIVU);
    endfunction

    function automatic logic [63:0] model(input logic [3:0] op, input logic [31:0] x, input logic [31:0] y,
                                          input logic [31:0] h, input logic [31:0] l);
        longint          sx, sy, sp, q, r;
        longint unsigned up;
        sx = $signed(x);
        sy = $signed(y);
        sp = sx * sy;
        up = {32'b0, x} * {32'b0, y};
        case (op)
            MULT:  return sp;
            MULTU: return up;
            DIV: begin
                if (y == 0) return {h, l};
                q = sx / sy;
                r = sx % sy;
                return {r[31:0], q[31:0]};
            end
            DIVU: begin
                if (y == 0) return {h, l};
                return {x % y, x / y};
            end
            MADD:  return {h, l} + sp;
            MADDU: return {h, l} + up;
            MSUB:  return {h, l} - sp;
            MSUBU: return {h, l} - up;
            default: return {h, l};
        endcase
    endfunction

    // Drives one op for a single cycle starting at posedge+1; returns at the next posedge+1.
    task automatic drive(input logic [3:0] op, input logic [31:0] av, input logic [31:0] bv);
        logic s_exp;
        exp_t e;
        md_valid = 1'b1;
        md_op    = op;
        a        = av;
        b        = bv;
        #1;
        s_exp = (tb_is_mul(op) || tb_is_div(op)) && !busy;
        check("start", {63'b0, start}, {63'b0, s_exp});
        if (s_exp) begin
            e.res = model(op, av, bv, mhi, mlo);
            e.cyc = tb_is_div(op) ? DC : MC;
            sb.push_back(e);
            {mhi, mlo} = e.res;
        end else if (!busy && op == MTHI) begin
            mhi = av;
        end else if (!busy && op == MTLO) begin
            mlo = av;
        end
        @(posedge clk);
        #1;
        md_valid = 1'b0;
        md_op    = NONE;
    endtask

    // Returns at posedge+1 of the first cycle with busy==0.
    task automatic wait_idle();
        int unsigned n;
        n = 0;
        while (busy && n < 40) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (busy) check("idle_timeout", {63'b0, busy}, 64'd0);
    endtask

    int unsigned bcnt = 0;
    logic        pb = 1'b0;
    always @(negedge clk) begin
        exp_t e;
        if (reset) begin
            sb.delete();
            bcnt = 0;
            pb   = 1'b0;
        end else begin
            if (busy) begin
                bcnt++;
            end else if (pb) begin
                if (sb.size() == 0) begin
                    check("spurious_commit", 64'd1, 64'd0);
                end else begin
                    e = sb.pop_front();
                    check("busy_len", 64'(bcnt), 64'(e.cyc));
                    check("commit_hilo", {hi, lo}, e.res);
                end
                bcnt = 0;
            end
            pb = busy;
        end
    end

    initial begin
        logic [3:0] rop;
        logic [31:0] ra, rb;
        reset    = 1'b1;
        md_valid = 1'b0;
        md_op    = NONE;
        a        = '0;
        b        = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", {63'b0, busy}, 64'd0);
        check("rst_hilo", {hi, lo}, 64'd0);
        reset = 1'b0;
        @(posedge clk);
        #1;

        drive(MULT, 32'hFFFFFFFE, 32'd3);
        check("no_update_at_start", {hi, lo}, 64'd0);
        check("busy_after_start", {63'b0, busy}, 64'd1);
        wait_idle();
        check("mult_hi", 64'(hi), 64'hFFFFFFFF);
        check("mult_lo", 64'(lo), 64'hFFFFFFFA);

        drive(DIVU, 32'd100, 32'd7);
        wait_idle();
        check("divu_hi", 64'(hi), 64'd2);
        check("divu_lo", 64'(lo), 64'd14);
        drive(DIV, 32'hFFFFFFF9, 32'd2);
        wait_idle();
        check("div_hi", 64'(hi), 64'hFFFFFFFF);
        check("div_lo", 64'(lo), 64'hFFFFFFFD);

        drive(MTHI, 32'h11, 32'd0);
        drive(MTLO, 32'h22, 32'd0);
        drive(DIV, 32'd5, 32'd0);
        wait_idle();
        check("div0_hi", 64'(hi), 64'h11);
        check("div0_lo", 64'(lo), 64'h22);
        drive(DIV, 32'h80000000, 32'hFFFFFFFF);
        wait_idle();
        check("ovf_hi", 64'(hi), 64'd0);
        check("ovf_lo", 64'(lo), 64'h80000000);

        drive(MTHI, 32'hDEAD, 32'd0);
        check("mthi_hi", 64'(hi), 64'hDEAD);
        check("mthi_busy", {63'b0, busy}, 64'd0);
        drive(MTLO, 32'hBEEF, 32'd0);
        check("mtlo_lo", 64'(lo), 64'hBEEF);
        check("mtlo_busy", {63'b0, busy}, 64'd0);

        drive(MULTU, 32'd3, 32'd4);
        drive(MTHI, 32'h1234, 32'd0);
        drive(DIV, 32'd9, 32'd3);
        wait_idle();
        drive(MULTU, 32'd7, 32'd6);
        wait_idle();
        check("b2b_hi", 64'(hi), 64'd0);
        check("b2b_lo", 64'(lo), 64'd42);

        drive(MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF);
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        reset = 1'b1;
        #1;
        check("abort_busy", {63'b0, busy}, 64'd0);
        check("abort_hilo", {hi, lo}, 64'd0);
        mhi = '0;
        mlo = '0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        repeat (15) @(posedge clk);
        #1;
        check("post_rst_busy", {63'b0, busy}, 64'd0);
        check("post_rst_hilo", {hi, lo}, 64'd0);

`ifdef MDU_MADD_EN
        drive(MTLO, 32'hFFFFFFFF, 32'd0);
        drive(MADDU, 32'd1, 32'd1);
        wait_idle();
        check("maddu_hilo", {hi, lo}, 64'h00000001_00000000);
        drive(MTHI, 32'd0, 32'd0);
        drive(MTLO, 32'd0, 32'd0);
        drive(MSUB, 32'd1, 32'd1);
        wait_idle();
        check("msub_hilo", {hi, lo}, 64'hFFFFFFFF_FFFFFFFF);
`else
        drive(MTLO, 32'h55, 32'd0);
        drive(MADD, 32'd5, 32'd5);
        repeat (MC + 2) @(posedge clk);
        #1;
        check("madd_off_busy", {63'b0, busy}, 64'd0);
        check("madd_off_hilo", {hi, lo}, 64'h00000000_00000055);
`endif

        for (int i = 0; i < 8; i++) begin
            rop = 4'($urandom_range(1, 4));
            ra  = $urandom();
            rb  = (i % 3 == 0) ? 32'($urandom_range(0, 9)) : $urandom();
            drive(rop, ra, rb);
            wait_idle();
            check("rand_hilo", {hi, lo}, {mhi, mlo});
        end

        repeat (3) @(posedge clk);
        #1;
        check("sb_drained", 64'(sb.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
